// File: rtl/fdb_pkg.sv
// ---------------------------------------------------------------------------
// fdb_pkg
//   Shared constants and types for the RV32I fetch/decode/branch front end.
//   Contents: opcode constants, the 5-bit ALU operation encoding shared with
//   the ALU, writeback-source constants, the decoded control bundle, and a
//   helper that maps funct3 (+ alternate bit) to an ALU operation.
// ---------------------------------------------------------------------------
package fdb_pkg;

    // Major opcodes (inst[6:0]) understood by this front end.
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    // ALU operation encoding, shared with the ALU.
    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_PASSB = 5'd10
    } alu_op_e;

    // Writeback source select.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Decoded control bundle. 'valid' is low for any opcode/funct3 the
    // decoder does not recognise; the top uses it to zero the immediate.
    typedef struct packed {
        logic       valid;
        logic       pc_sel;
        logic       alu_src1;
        logic       alu_src2;
        logic       reg_we;
        logic       mem_we;
        logic [1:0] wb_sel;
        alu_op_e    alu_op;
    } ctrl_t;

    // funct3 -> ALU op for the OP / OP-IMM groups. 'alt' selects SUB over
    // ADD and SRA over SRL (funct7[5] / inst[30]); callers must pass 0 for
    // OP-IMM funct3=000, since there is no "subi".
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fetch_decode_branch_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Sign-extended immediate generator. Picks the I/S/B/U/J layout from the
//   opcode and reassembles the scattered immediate bits.
//   Ports:
//     inst_i  in  32  instruction word
//     imm_o   out 32  sign-extended immediate (0 for R-type and unknown opcodes)
// ---------------------------------------------------------------------------
module imm_gen
    import fdb_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        imm_o = 32'h0;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {inst_i[31:12], 12'h000};
            OPC_JAL:
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_branch.sv
// ---------------------------------------------------------------------------
// fetch_decode_branch
//   RV32I single-cycle front end: PC register, instruction decoder and
//   branch comparator. Decode, immediate and BrEq are combinational; only
//   the PC is registered.
//   Ports:
//     clk        in   1   rising-edge clock
//     rst        in   1   synchronous active-high reset
//     inst       in   32  instruction at address pc
//     Addr       in   32  redirect target from the ALU (bits [1:0] ignored)
//     rs1_data   in   32  register file read data 1
//     rs2_data   in   32  register file read data 2
//     pc         out  32  current PC
//     PCSel      out  1   1: next pc = Addr, 0: next pc = pc+4
//     ALUSrc1    out  1   ALU A: 0 = rs1_data, 1 = pc
//     ALUSrc2    out  1   ALU B: 0 = rs2_data, 1 = Imm
//     RegWE      out  1   register file write enable
//     MemWE      out  1   data memory write enable
//     WBSel      out  2   00 = ALU, 01 = memory, 10 = pc+4
//     Imm        out  32  sign-extended immediate
//     ALUop      out  5   ALU operation (fdb_pkg::alu_op_e)
//     rs1/rs2/rd out  5   raw register fields of inst
//     BrEq       out  1   rs1_data == rs2_data
// ---------------------------------------------------------------------------
module fetch_decode_branch
    import fdb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] Addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] pc,
    output logic        PCSel,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic        RegWE,
    output logic        MemWE,
    output logic [1:0]  WBSel,
    output logic [31:0] Imm,
    output logic [4:0]  ALUop,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        BrEq
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm_raw;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    ctrl_t       ctrl;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7_b5 = inst[30];

    // Register fields are passed through untouched for every format.
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign rd  = inst[11:7];

    assign BrEq = (rs1_data == rs2_data);

    imm_gen u_imm_gen (
        .inst_i (inst),
        .imm_o  (imm_raw)
    );

    // ---------------------------------------------------------------------
    // Decoder. The default is the "unknown instruction" bundle: everything
    // off, ALU_ADD, and valid=0. Recognised encodings override it.
    // ---------------------------------------------------------------------
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        ctrl.wb_sel = WB_ALU;

        case (opcode)
            OPC_OP: begin
                ctrl.valid  = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.alu_op = alu_from_funct3(funct3, funct7_b5);
            end
            OPC_OP_IMM: begin
                ctrl.valid    = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.alu_src2 = 1'b1;
                // inst[30] is immediate data for addi, only an op selector
                // for the shift-right group.
                ctrl.alu_op   = alu_from_funct3(funct3,
                                                (funct3 == 3'b101) && funct7_b5);
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    ctrl.valid    = 1'b1;
                    ctrl.reg_we   = 1'b1;
                    ctrl.alu_src2 = 1'b1;
                    ctrl.wb_sel   = WB_MEM;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    ctrl.valid    = 1'b1;
                    ctrl.mem_we   = 1'b1;
                    ctrl.alu_src2 = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    ctrl.valid    = 1'b1;
                    ctrl.alu_src1 = 1'b1;
                    ctrl.alu_src2 = 1'b1;
                    // funct3[0] = 0: beq, 1: bne.
                    ctrl.pc_sel   = funct3[0] ? !BrEq : BrEq;
                end
            end
            OPC_JAL: begin
                ctrl.valid    = 1'b1;
                ctrl.alu_src1 = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.pc_sel   = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl.valid    = 1'b1;
                    ctrl.alu_src2 = 1'b1;
                    ctrl.pc_sel   = 1'b1;
                    ctrl.reg_we   = 1'b1;
                    ctrl.wb_sel   = WB_PC4;
                end
            end
            OPC_LUI: begin
                ctrl.valid    = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.alu_op   = ALU_PASSB;
            end
            OPC_AUIPC: begin
                ctrl.valid    = 1'b1;
                ctrl.alu_src1 = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.reg_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting controls are suppressed during reset so nothing is
    // written and no redirect competes with the reset PC.
    assign PCSel   = ctrl.pc_sel & ~rst;
    assign RegWE   = ctrl.reg_we & ~rst;
    assign MemWE   = ctrl.mem_we & ~rst;
    assign ALUSrc1 = ctrl.alu_src1;
    assign ALUSrc2 = ctrl.alu_src2;
    assign WBSel   = ctrl.wb_sel;
    assign ALUop   = ctrl.alu_op;
    assign Imm     = ctrl.valid ? imm_raw : 32'h0;

    // ---------------------------------------------------------------------
    // PC register. Redirect targets are forced word-aligned; the +4 path
    // wraps naturally in 32 bits.
    // ---------------------------------------------------------------------
    assign pc_d = PCSel ? (Addr & ~32'h3) : (pc_q + 32'd4);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is
        // sampled on the clock edge, so it lives inside the clocked branch.
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_fetch_decode_branch.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_branch
//   Directed bench for fetch_decode_branch: hand-computed expectations for
//   PC sequencing, decode of each supported opcode, immediates, branch
//   comparison, address alignment, PC wrap and reset priority.
// ---------------------------------------------------------------------------
module tb_fetch_decode_branch;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] Addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        PCSel;
    logic        ALUSrc1;
    logic        ALUSrc2;
    logic        RegWE;
    logic        MemWE;
    logic [1:0]  WBSel;
    logic [31:0] Imm;
    logic [4:0]  ALUop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        BrEq;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_branch #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .Addr     (Addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pc       (pc),
        .PCSel    (PCSel),
        .ALUSrc1  (ALUSrc1),
        .ALUSrc2  (ALUSrc2),
        .RegWE    (RegWE),
        .MemWE    (MemWE),
        .WBSel    (WBSel),
        .Imm      (Imm),
        .ALUop    (ALUop),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .BrEq     (BrEq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply an instruction and let the combinational decode settle.
    task automatic apply(input logic [31:0] i);
        inst = i;
        #1;
    endtask

    // Check the full control bundle in one call.
    task automatic check_ctrl(input string tag, input logic pcsel,
                              input logic s1, input logic s2, input logic rwe,
                              input logic mwe, input logic [1:0] wb,
                              input logic [4:0] op);
        check({tag, ".PCSel"},   32'(PCSel),   32'(pcsel));
        check({tag, ".ALUSrc1"}, 32'(ALUSrc1), 32'(s1));
        check({tag, ".ALUSrc2"}, 32'(ALUSrc2), 32'(s2));
        check({tag, ".RegWE"},   32'(RegWE),   32'(rwe));
        check({tag, ".MemWE"},   32'(MemWE),   32'(mwe));
        check({tag, ".WBSel"},   32'(WBSel),   32'(wb));
        check({tag, ".ALUop"},   32'(ALUop),   32'(op));
    endtask

    initial begin
        rst      = 1'b1;
        inst     = 32'h010000EF;   // jal: would redirect if reset did not win
        Addr     = 32'h0000_0040;
        rs1_data = 32'h0;
        rs2_data = 32'h0;

        // Reset: pc loads 0, write/redirect controls held low.
        step();
        check("rst.pc", pc, 32'h0);
        check("rst.PCSel", 32'(PCSel), 32'h0);
        check("rst.RegWE", 32'(RegWE), 32'h0);

        // Sequential fetch: 0, 4, 8.
        rst = 1'b0;
        apply(32'h00500093);       // addi x1,x0,5
        check("seq.pc0", pc, 32'h0);
        step();
        check("seq.pc4", pc, 32'h4);
        step();
        check("seq.pc8", pc, 32'h8);

        // addi x1,x0,5
        check("addi.rd", 32'(rd), 32'd1);
        check("addi.rs1", 32'(rs1), 32'd0);
        check("addi.Imm", Imm, 32'd5);
        check_ctrl("addi", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0);

        // add x3,x1,x2
        apply(32'h002081B3);
        check("add.rs1", 32'(rs1), 32'd1);
        check("add.rs2", 32'(rs2), 32'd2);
        check("add.rd", 32'(rd), 32'd3);
        check_ctrl("add", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0);

        // sub x4,x1,x2
        apply(32'h40208233);
        check("sub.ALUop", 32'(ALUop), 32'd1);
        check("sub.rd", 32'(rd), 32'd4);

        // srai x1,x1,3: inst[30] selects SRA; imm keeps the raw I field.
        apply(32'h4030D093);
        check("srai.ALUop", 32'(ALUop), 32'd7);
        check("srai.Imm", Imm, 32'h0000_0403);

        // beq x1,x2,+8 taken; Addr low bits must be dropped.
        rs1_data = 32'd7;
        rs2_data = 32'd7;
        Addr     = 32'h0000_0013;
        apply(32'h00208463);
        check("beq.BrEq", 32'(BrEq), 32'h1);
        check("beq.Imm", Imm, 32'd8);
        check_ctrl("beq_t", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
        step();
        check("beq_t.pc", pc, 32'h10);

        // beq not taken.
        rs2_data = 32'd6;
        #1;
        check("beq_nt.BrEq", 32'(BrEq), 32'h0);
        check("beq_nt.PCSel", 32'(PCSel), 32'h0);
        step();
        check("beq_nt.pc", pc, 32'h14);

        // bne x1,x2,+8: taken when unequal, not taken when equal.
        apply(32'h00209463);
        check("bne_t.PCSel", 32'(PCSel), 32'h1);
        rs2_data = 32'd7;
        #1;
        check("bne_nt.PCSel", 32'(PCSel), 32'h0);

        // Branch with unsupported funct3 (010): treated as unknown.
        apply(32'h0020A463);
        check("brx.Imm", Imm, 32'h0);
        check_ctrl("brx", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);

        // sw x2,4(x1)
        apply(32'h0020A223);
        check("sw.Imm", Imm, 32'd4);
        check_ctrl("sw", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 5'd0);

        // lw x1,-4(x2): negative immediate sign extension.
        apply(32'hFFC12083);
        check("lw.Imm", Imm, 32'hFFFF_FFFC);
        check("lw.rs1", 32'(rs1), 32'd2);
        check_ctrl("lw", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 5'd0);

        // jal x1,+16
        apply(32'h010000EF);
        check("jal.Imm", Imm, 32'd16);
        check_ctrl("jal", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0);

        // jalr x1,0(x1)
        apply(32'h000080E7);
        check("jalr.Imm", Imm, 32'h0);
        check_ctrl("jalr", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0);

        // lui x1,0x12345
        apply(32'h123450B7);
        check("lui.Imm", Imm, 32'h1234_5000);
        check_ctrl("lui", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 5'd10);

        // auipc x1,0x1
        apply(32'h00001097);
        check("auipc.Imm", Imm, 32'h0000_1000);
        check_ctrl("auipc", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 5'd0);

        // Illegal instruction: everything off, raw fields still visible.
        apply(32'hFFFFFFFF);
        check("ill.Imm", Imm, 32'h0);
        check("ill.rd", 32'(rd), 32'd31);
        check_ctrl("ill", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);

        // PC wrap: jump to top word, then +4 wraps to 0.
        Addr = 32'hFFFF_FFFE;
        apply(32'h010000EF);
        step();
        check("wrap.top", pc, 32'hFFFF_FFFC);
        apply(32'hFFFFFFFF);
        step();
        check("wrap.zero", pc, 32'h0);
        step();
        check("wrap.four", pc, 32'h4);

        // Reset mid-run beats a simultaneous redirect.
        Addr = 32'h0000_0040;
        apply(32'h010000EF);
        rst = 1'b1;
        #1;
        check("rstmid.PCSel", 32'(PCSel), 32'h0);
        check("rstmid.RegWE", 32'(RegWE), 32'h0);
        step();
        check("rstmid.pc", pc, 32'h0);
        rst = 1'b0;
        #1;
        check("rstmid.PCSel_rel", 32'(PCSel), 32'h1);
        step();
        check("rstmid.redirect", pc, 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
